// File: rtl/sec_abort_sequencer.sv
// Abort sequencer between the security monitor and the ROB: queues tainted-branch
// alerts from two units and issues them one at a time, with a hold-off after each accept.
//
// state | meaning
// IDLE  | nothing presented; waits for a queued entry
// ISSUE | head entry presented to the ROB, waiting for ready
// HOLD  | rollback settling window after an accepted abort
module sec_abort_sequencer #(
  parameter int ROB_IDX_W      = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_alert_valid_0,
  input  logic [ROB_IDX_W-1:0] io_alert_rob_idx_0,
  input  logic [ROB_IDX_W-1:0] io_alert_yrot_0,
  input  logic                 io_alert_valid_1,
  input  logic [ROB_IDX_W-1:0] io_alert_rob_idx_1,
  input  logic [ROB_IDX_W-1:0] io_alert_yrot_1,
  input  logic                 io_flush,
  output logic                 io_abort_valid,
  input  logic                 io_abort_ready,
  output logic [ROB_IDX_W-1:0] io_abort_rob_idx,
  output logic [ROB_IDX_W-1:0] io_abort_yrot,
  output logic                 io_busy,
  output logic                 io_overflow,
  output logic [CNT_W-1:0]     io_alert_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [ROB_IDX_W-1:0] q_rob  [FIFO_DEPTH];
  logic [ROB_IDX_W-1:0] q_yrot [FIFO_DEPTH];

  logic [OCC_W-1:0]  wr_ptr, rd_ptr, occ, free;
  logic [OCC_W-1:0]  wr_ptr_nxt, rd_ptr_nxt, occ_nxt;
  logic [PTR_W-1:0]  wr_idx0, wr_idx1, rd_idx;
  logic [1:0]        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  alert_count, count_nxt;
  logic [CNT_W:0]    count_sum;
  logic [1:0]        n_enq;
  logic              overflow;
  logic              deq, req0, req1, en0, en1, drop;

  assign occ    = wr_ptr - rd_ptr;
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign deq    = (state == ST_ISSUE) && io_abort_ready;

  // A slot freed by this cycle's dequeue is usable by this cycle's alerts.
  assign free = DEPTH_L - occ + OCC_W'(deq);

  // Same ROB index on both units is a single abort; unit 0 carries it.
  assign req0 = io_alert_valid_0;
  assign req1 = io_alert_valid_1 &&
                !(io_alert_valid_0 && (io_alert_rob_idx_0 == io_alert_rob_idx_1));

  assign en0  = !io_flush && req0 && (free != '0);
  assign en1  = !io_flush && req1 && (free > OCC_W'(req0));
  assign drop = !io_flush && ((req0 && !en0) || (req1 && !en1));

  assign n_enq   = {1'b0, en0} + {1'b0, en1};
  assign wr_idx0 = wr_ptr[PTR_W-1:0];
  assign wr_idx1 = wr_idx0 + PTR_W'(en0);

  assign wr_ptr_nxt = wr_ptr + OCC_W'(n_enq);
  assign rd_ptr_nxt = rd_ptr + OCC_W'(deq);
  assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  assign count_sum = {1'b0, alert_count} + (CNT_W+1)'(n_enq);
  assign count_nxt = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (occ != '0) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (deq) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HOLD_W'(HOLDOFF_CYCLES);
        end
      end
      ST_HOLD: begin
        hold_nxt = hold_cnt - HOLD_W'(1);
        if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt = (occ_nxt != '0) ? ST_ISSUE : ST_IDLE;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      overflow    <= 1'b0;
      alert_count <= '0;
    end else begin
      alert_count <= count_nxt;
      overflow    <= overflow | drop;
      if (io_flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        state    <= ST_IDLE;
        hold_cnt <= '0;
      end else begin
        wr_ptr   <= wr_ptr_nxt;
        rd_ptr   <= rd_ptr_nxt;
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
      end
    end
  end

  // Storage needs no reset: the read side is gated by the valid state.
  always_ff @(posedge clock) begin
    if (en0) begin
      q_rob[wr_idx0]  <= io_alert_rob_idx_0;
      q_yrot[wr_idx0] <= io_alert_yrot_0;
    end
    if (en1) begin
      q_rob[wr_idx1]  <= io_alert_rob_idx_1;
      q_yrot[wr_idx1] <= io_alert_yrot_1;
    end
  end

  assign io_abort_valid   = (state == ST_ISSUE);
  assign io_abort_rob_idx = io_abort_valid ? q_rob[rd_idx]  : '0;
  assign io_abort_yrot    = io_abort_valid ? q_yrot[rd_idx] : '0;
  assign io_busy          = (occ != '0) || (state != ST_IDLE);
  assign io_overflow      = overflow;
  assign io_alert_count   = alert_count;

endmodule

// File: doc/sec_abort_sequencer.md
Name: sec_abort_sequencer

Overview:
- Sits between the security monitor and the ROB.
- Takes the per-unit tainted-branch alerts (unit 0 = jump unit ALU, unit 1 = CSR exe unit ALU) and buffers them in a small FIFO.
- Issues one abort request at a time to the ROB over a valid/ready handshake.
- After each accepted abort it waits a hold-off window so the ROB rollback settles before the next abort is presented.

Parameters:
- ROB_IDX_W, 6, width of rob_idx and yrot fields.
- FIFO_DEPTH, 4, abort queue entries (power of 2, >= 2).
- HOLDOFF_CYCLES, 2, idle cycles after each accepted abort (>= 1).
- CNT_W, 16, width of the saturating accepted-alert counter.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- io_alert_valid_0  in  1  unit-0 alert
- io_alert_rob_idx_0  in  ROB_IDX_W  unit-0 aborted uop ROB index
- io_alert_yrot_0  in  ROB_IDX_W  unit-0 taint root (yrot)
- io_alert_valid_1  in  1  unit-1 alert
- io_alert_rob_idx_1  in  ROB_IDX_W  unit-1 aborted uop ROB index
- io_alert_yrot_1  in  ROB_IDX_W  unit-1 yrot
- io_flush  in  1  pipeline flush; discards all queued and in-flight aborts
- io_abort_valid  out  1  abort request to ROB
- io_abort_ready  in  1  ROB accepts abort
- io_abort_rob_idx  out  ROB_IDX_W  head entry ROB index
- io_abort_yrot  out  ROB_IDX_W  head entry yrot
- io_busy  out  1  queue non-empty or state != IDLE
- io_overflow  out  1  sticky: an alert was dropped because the queue was full
- io_alert_count  out  CNT_W  saturating count of enqueued alerts

Behaviour:
- Reset (synchronous): FIFO empty, state IDLE, hold-off counter 0, io_overflow 0, io_alert_count 0. All outputs are 0 in the cycle after reset is sampled high. Reset mid-handshake abandons the entry.
- Enqueue per cycle:
  - Source 0 is written before source 1, so FIFO order is 0 then 1.
  - If both valid and rob_idx_0 == rob_idx_1, only source 0 is enqueued, and the count increments by 1.
  - Free slots = FIFO_DEPTH - occupancy + (dequeue this cycle ? 1 : 0). A dequeue frees its slot in the same cycle.
  - An alert that finds no free slot is dropped and io_overflow is set. When only one slot is free, source 0 wins.
  - io_overflow is cleared only by reset.
- Counter: increments by the number of entries actually enqueued (0/1/2) and saturates at all-ones. Saturated +2 stays at all-ones; all-ones minus 1, +2, goes to all-ones.
- State machine:
  - IDLE: if the FIFO is non-empty, go to ISSUE next cycle.
  - ISSUE: io_abort_valid = 1 with io_abort_rob_idx/io_abort_yrot = FIFO head. These hold stable while ready = 0. On valid && ready: dequeue head, load the hold-off counter with HOLDOFF_CYCLES, go to HOLD.
  - HOLD: io_abort_valid = 0. Decrement the counter each cycle; at 1 go to ISSUE if the FIFO is non-empty after this cycle's enqueue, else go to IDLE.
- Latency: an alert enqueued in cycle N into an empty FIFO in IDLE produces io_abort_valid in cycle N+2. Accepted aborts are spaced exactly HOLDOFF_CYCLES+1 cycles apart when ready is held high.
- Outputs are 0 whenever io_abort_valid = 0.
- Flush:
  - Next cycle: FIFO empty, state IDLE, hold-off counter 0.
  - Alerts arriving in the flush cycle are discarded and not counted.
  - If ready is asserted in the flush cycle, the handshake is still considered completed by the ROB; the sequencer just discards state.
  - Counter and io_overflow are not affected.
- io_busy = (occupancy != 0) || (state != IDLE). Registered view, updated the same cycle as state.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses an extra bit so full and empty are distinguished.

Test Plan:
- Single alert: valid_0 = 1, rob_idx_0 = 0x05, yrot_0 = 0x03 at cycle 10, ready = 1 -> abort_valid at cycle 12 with 0x05/0x03; io_busy = 0 by cycle 15; count = 1.
- Dual distinct: valid_0/1 at cycle 10, rob_idx 0x07 / 0x09, ready = 1 -> aborts 0x07 at cycle 12 and 0x09 at cycle 15 (HOLDOFF = 2); count = 2.
- Duplicate: both sources rob_idx 0x11 in one cycle -> exactly one abort 0x11; count = 1.
- Backpressure plus overflow: ready = 0, 3 cycles of dual distinct alerts (6 alerts, depth 4) -> first 4 queued in order, io_overflow = 1, count = 4. The head stays stable until ready, then the 4 entries drain in order.
- Flush: queue 3 entries, assert io_flush during ISSUE together with a new alert -> next cycle abort_valid = 0 and busy = 0; the new alert is not counted; overflow is unchanged.
- Saturation and reset: preload the counter to 0xFFFE, enqueue a dual alert -> count = 0xFFFF. Assert reset during HOLD -> next cycle all outputs 0 and count = 0.
